// File: rtl/detect_winner_seq.sv
// -----------------------------------------------------------------------------
// detect_winner_seq
//
// Sequential connect-WIN winner detector for a ROWS x COLS board.
// A start request in IDLE snapshots the board. The FSM then examines one
// candidate line per clock. The order is direction first (outer), then row,
// then column (inner). The first line that is fully occupied by a single owner
// ends the scan. If no line qualifies, the scan runs through all 4*ROWS*COLS
// candidates and then reports a tie or "still playing".
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   start         evaluate the current board (only honoured in IDLE)
//   game_board    occupancy, bit r*COLS+c set = cell (r,c) filled
//   player_cells  owner per cell, 1 = player 2, 0 = player 1
//   busy          high while the scan is running
//   done          one-cycle pulse, result outputs freshly written
//   game_status   00 playing, 01 p1 wins, 10 p2 wins, 11 tie
//   win_dir       0 horiz, 1 vert, 2 diag (+1,+1), 3 anti-diag (+1,-1)
//   win_row       start row of the winning line
//   win_col       start column of the winning line
//   win_mask      cells of the winning line
// -----------------------------------------------------------------------------
module detect_winner_seq #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int WIN  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ROWS*COLS-1:0]     game_board,
   input  logic [ROWS*COLS-1:0]     player_cells,
   output logic                     busy,
   output logic                     done,
   output logic [1:0]               game_status,
   output logic [1:0]               win_dir,
   output logic [$clog2(ROWS)-1:0]  win_row,
   output logic [$clog2(COLS)-1:0]  win_col,
   output logic [ROWS*COLS-1:0]     win_mask
);

   localparam int N  = ROWS * COLS;
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam logic [N-1:0] ONE = N'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      REPORT = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [N-1:0]    board_reg, player_reg;
   logic [1:0]      dir_reg;
   logic [RW-1:0]   row_reg;
   logic [CW-1:0]   col_reg;

   logic [N-1:0]    cand_mask;
   logic            cand_valid;
   logic            cand_full, cand_p1, cand_p2, cand_match;
   logic            last_cand;

   // Cells covered by the current candidate. A line that leaves the board is
   // flagged invalid; its partial mask is never used.
   always_comb begin
      int dr, dc, rr, cc;
      dr         = 0;
      dc         = 1;
      rr         = 0;
      cc         = 0;
      cand_valid = 1'b1;
      cand_mask  = '0;
      case (dir_reg)
         2'd0:    begin dr = 0; dc = 1;  end
         2'd1:    begin dr = 1; dc = 0;  end
         2'd2:    begin dr = 1; dc = 1;  end
         default: begin dr = 1; dc = -1; end
      endcase
      for (int i = 0; i < WIN; i++) begin
         rr = int'(row_reg) + i * dr;
         cc = int'(col_reg) + i * dc;
         if (rr >= ROWS || cc < 0 || cc >= COLS)
            cand_valid = 1'b0;
         else
            cand_mask = cand_mask | (ONE << (rr * COLS + cc));
      end
   end

   // A match needs every cell occupied and a uniform owner. Because WIN >= 2,
   // the mask is never empty, so p1 and p2 cannot both be true.
   assign cand_full  = (board_reg & cand_mask) == cand_mask;
   assign cand_p2    = (player_reg & cand_mask) == cand_mask;
   assign cand_p1    = (player_reg & cand_mask) == '0;
   assign cand_match = cand_valid && cand_full && (cand_p1 || cand_p2);

   assign last_cand = (dir_reg == 2'd3) &&
                      (row_reg == RW'(ROWS - 1)) &&
                      (col_reg == CW'(COLS - 1));

   // Status flags come straight from the state register, so no input reaches
   // an output combinationally.
   assign busy = (state_reg == SCAN);
   assign done = (state_reg == REPORT);

   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = SCAN;
         SCAN:    if (cand_match || last_cand) state_next = REPORT;
         REPORT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         board_reg   <= '0;
         player_reg  <= '0;
         dir_reg     <= 2'd0;
         row_reg     <= '0;
         col_reg     <= '0;
         game_status <= 2'b00;
         win_dir     <= 2'd0;
         win_row     <= '0;
         win_col     <= '0;
         win_mask    <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  board_reg  <= game_board;
                  player_reg <= player_cells;
                  dir_reg    <= 2'd0;
                  row_reg    <= '0;
                  col_reg    <= '0;
               end
            end
            SCAN: begin
               if (cand_match) begin
                  game_status <= cand_p2 ? 2'b10 : 2'b01;
                  win_dir     <= dir_reg;
                  win_row     <= row_reg;
                  win_col     <= col_reg;
                  win_mask    <= cand_mask;
               end else if (last_cand) begin
                  game_status <= (&board_reg) ? 2'b11 : 2'b00;
                  win_dir     <= 2'd0;
                  win_row     <= '0;
                  win_col     <= '0;
                  win_mask    <= '0;
               end else if (col_reg == CW'(COLS - 1)) begin
                  col_reg <= '0;
                  if (row_reg == RW'(ROWS - 1)) begin
                     row_reg <= '0;
                     dir_reg <= dir_reg + 2'd1;
                  end else begin
                     row_reg <= row_reg + RW'(1);
                  end
               end else begin
                  col_reg <= col_reg + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_detect_winner_seq.sv
// -----------------------------------------------------------------------------
// tb_detect_winner_seq
//
// Testbench for detect_winner_seq. A default 4x4/WIN=4 instance is checked
// on every cycle against a line-search model. A 6x7/WIN=4 instance is checked
// against literal expectations and the same model.
// -----------------------------------------------------------------------------
module tb_detect_winner_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start;
   logic [15:0] game_board, player_cells;
   logic        busy, done;
   logic [1:0]  game_status, win_dir;
   logic [1:0]  win_row, win_col;
   logic [15:0] win_mask;

   logic        start_b;
   logic [41:0] game_board_b, player_cells_b;
   logic        busy_b, done_b;
   logic [1:0]  game_status_b, win_dir_b;
   logic [2:0]  win_row_b, win_col_b;
   logic [41:0] win_mask_b;

   detect_winner_seq u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .game_board   (game_board),
      .player_cells (player_cells),
      .busy         (busy),
      .done         (done),
      .game_status  (game_status),
      .win_dir      (win_dir),
      .win_row      (win_row),
      .win_col      (win_col),
      .win_mask     (win_mask)
   );

   detect_winner_seq #(.ROWS(6), .COLS(7), .WIN(4)) u_dut_b (
      .clk          (clk),
      .rst          (rst),
      .start        (start_b),
      .game_board   (game_board_b),
      .player_cells (player_cells_b),
      .busy         (busy_b),
      .done         (done_b),
      .game_status  (game_status_b),
      .win_dir      (win_dir_b),
      .win_row      (win_row_b),
      .win_col      (win_col_b),
      .win_mask     (win_mask_b)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Search for the first qualifying line in priority order, using board
   // coordinates. k is the 1-based candidate number that ends the scan.
   function automatic void model_eval(input int rows, input int cols, input int win,
                                      input logic [63:0] brd, input logic [63:0] ply,
                                      output int k, output logic [1:0] st,
                                      output logic [1:0] dir, output int wr,
                                      output int wc, output logic [63:0] mask);
      int   drs[4];
      int   dcs[4];
      logic found;
      logic full;
      drs   = '{0, 1, 1, 1};
      dcs   = '{1, 0, 1, -1};
      k     = 0;
      st    = 2'b00;
      dir   = 2'd0;
      wr    = 0;
      wc    = 0;
      mask  = '0;
      found = 1'b0;
      full  = 1'b1;
      for (int d = 0; d < 4; d++) begin
         for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
               if (!found) begin
                  logic        ok;
                  logic        own;
                  logic [63:0] m;
                  int          rr, cc, idx;
                  k++;
                  ok  = 1'b1;
                  own = 1'b0;
                  m   = '0;
                  for (int i = 0; i < win; i++) begin
                     rr = r + i * drs[d];
                     cc = c + i * dcs[d];
                     if (rr < 0 || rr >= rows || cc < 0 || cc >= cols) begin
                        ok = 1'b0;
                     end else begin
                        idx = rr * cols + cc;
                        if (!brd[idx[5:0]]) ok = 1'b0;
                        else if (i == 0) own = ply[idx[5:0]];
                        else if (ply[idx[5:0]] !== own) ok = 1'b0;
                        m[idx[5:0]] = 1'b1;
                     end
                  end
                  if (ok) begin
                     found = 1'b1;
                     st    = own ? 2'b10 : 2'b01;
                     dir   = 2'(d);
                     wr    = r;
                     wc    = c;
                     mask  = m;
                  end
               end
            end
         end
      end
      if (!found) begin
         k = 4 * rows * cols;
         for (int idx = 0; idx < rows * cols; idx++)
            if (!brd[idx[5:0]]) full = 1'b0;
         st = full ? 2'b11 : 2'b00;
      end
   endfunction

   // Cycle model of the 4x4 instance: m_left counts remaining scan cycles.
   int          m_left = 0;
   logic        m_done = 1'b0;
   logic [1:0]  m_st = '0, m_dir = '0, m_row = '0, m_col = '0;
   logic [15:0] m_mask = '0;
   logic [1:0]  p_st = '0, p_dir = '0, p_row = '0, p_col = '0;
   logic [15:0] p_mask = '0;

   always @(posedge clk) begin
      int          k, wr, wc;
      logic [1:0]  st, dr;
      logic [63:0] mk;
      if (rst) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_st   <= 2'b00;
         m_dir  <= 2'd0;
         m_row  <= 2'd0;
         m_col  <= 2'd0;
         m_mask <= '0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_left > 1) begin
         m_left <= m_left - 1;
      end else if (m_left == 1) begin
         m_left <= 0;
         m_done <= 1'b1;
         m_st   <= p_st;
         m_dir  <= p_dir;
         m_row  <= p_row;
         m_col  <= p_col;
         m_mask <= p_mask;
      end else if (start) begin
         model_eval(4, 4, 4, 64'(game_board), 64'(player_cells), k, st, dr, wr, wc, mk);
         m_left <= k;
         p_st   <= st;
         p_dir  <= dr;
         p_row  <= 2'(wr);
         p_col  <= 2'(wc);
         p_mask <= mk[15:0];
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_cmp++;
         if (busy !== (m_left > 0) || done !== m_done || game_status !== m_st ||
             win_dir !== m_dir || win_row !== m_row || win_col !== m_col ||
             win_mask !== m_mask) begin
            n_bad++;
            $display("FAIL cycle_check t=%0t busy=%b/%b done=%b/%b status=%b/%b dir=%0d/%0d row=%0d/%0d col=%0d/%0d mask=%h/%h",
                     $time, busy, (m_left > 0), done, m_done, game_status, m_st,
                     win_dir, m_dir, win_row, m_row, win_col, m_col, win_mask, m_mask);
         end
      end
   end

   // Launch a scan on the 4x4 instance and check the done cycle and results.
   // Cycle 1 is the cycle right after the edge that samples start. Start is
   // held high again during cycles [repulse_at, repulse_at+3] when
   // repulse_at > 0.
   task automatic run_a(input string name, input logic [15:0] b, input logic [15:0] p,
                        input int exp_done, input logic [1:0] es, input logic [1:0] ed,
                        input logic [1:0] er, input logic [1:0] ec,
                        input logic [15:0] em, input int repulse_at);
      int cyc;
      @(negedge clk);
      game_board   = b;
      player_cells = p;
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      game_board   = ~b;
      player_cells = ~p;
      cyc = 1;
      while (!done && cyc < 300) begin
         start = (repulse_at > 0 && cyc >= repulse_at && cyc <= repulse_at + 3);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: no done after %0d cycles", name, cyc);
      end
      $display("case %s: done in cycle %0d status %b dir %0d row %0d col %0d mask %h",
               name, cyc, game_status, win_dir, win_row, win_col, win_mask);
      chk({name, "_done_cycle"}, 64'(cyc), 64'(exp_done));
      chk({name, "_status"}, 64'(game_status), 64'(es));
      chk({name, "_dir"}, 64'(win_dir), 64'(ed));
      chk({name, "_row"}, 64'(win_row), 64'(er));
      chk({name, "_col"}, 64'(win_col), 64'(ec));
      chk({name, "_mask"}, 64'(win_mask), 64'(em));
   endtask

   initial begin
      int          k, wr, wc, cyc;
      logic [1:0]  st, dr;
      logic [63:0] mk;
      logic        saw;

      rst            = 1'b1;
      start          = 1'b0;
      start_b        = 1'b0;
      game_board     = '0;
      player_cells   = '0;
      game_board_b   = '0;
      player_cells_b = '0;

      // Literal expectations that pin the model itself.
      model_eval(4, 4, 4, 64'h000F, 64'h0000, k, st, dr, wr, wc, mk);
      chk("model_row0_k", 64'(k), 64'd1);
      chk("model_row0_mask", mk, 64'h000F);
      model_eval(4, 4, 4, 64'h2222, 64'h2222, k, st, dr, wr, wc, mk);
      chk("model_col1_k", 64'(k), 64'd18);
      chk("model_col1_st", 64'(st), 64'd2);
      model_eval(4, 4, 4, 64'h1248, 64'h0000, k, st, dr, wr, wc, mk);
      chk("model_anti_k", 64'(k), 64'd52);
      chk("model_anti_dir", 64'(dr), 64'd3);
      model_eval(4, 4, 4, 64'hFFFF, 64'hC3C3, k, st, dr, wr, wc, mk);
      chk("model_tie_st", 64'(st), 64'd3);
      chk("model_tie_k", 64'(k), 64'd64);
      model_eval(6, 7, 4, 64'h41_0410_0000, 64'h0, k, st, dr, wr, wc, mk);
      chk("model_6x7_k", 64'(k), 64'd147);
      chk("model_6x7_rc", 64'(wr * 10 + wc), 64'd26);

      repeat (2) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_status", 64'(game_status), 64'd0);
      chk("reset_mask", 64'(win_mask), 64'd0);
      chk("reset_b_busy", 64'(busy_b), 64'd0);
      chk("reset_b_done", 64'(done_b), 64'd0);
      rst    = 1'b0;
      chk_en = 1'b1;

      run_a("row0_p1",    16'h000F, 16'h0000,  2, 2'b01, 2'd0, 2'd0, 2'd0, 16'h000F, 0);
      // Column 1 is candidate 18 (after 16 horizontal and 1 vertical miss).
      run_a("col1_p2",    16'h2222, 16'h2222, 19, 2'b10, 2'd1, 2'd0, 2'd1, 16'h2222, 0);
      run_a("anti_p1",    16'h1248, 16'h0000, 53, 2'b01, 2'd3, 2'd0, 2'd3, 16'h1248, 0);
      run_a("tie",        16'hFFFF, 16'hC3C3, 65, 2'b11, 2'd0, 2'd0, 2'd0, 16'h0000, 0);
      run_a("mixed_row",  16'h000F, 16'h0007, 65, 2'b00, 2'd0, 2'd0, 2'd0, 16'h0000, 0);
      run_a("restart_p2", 16'h000F, 16'h000F,  2, 2'b10, 2'd0, 2'd0, 2'd0, 16'h000F, 0);
      run_a("diag_p2",    16'h8421, 16'hFFFF, 34, 2'b10, 2'd2, 2'd0, 2'd0, 16'h8421, 0);
      run_a("anti_repulse", 16'h1248, 16'h0000, 53, 2'b01, 2'd3, 2'd0, 2'd3, 16'h1248, 5);

      // Reset in cycle 10 of a scan clears the results and suppresses done.
      @(negedge clk);
      game_board   = 16'hFFFF;
      player_cells = 16'hC3C3;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      $display("case rst_mid: reset applied in scan cycle %0d", cyc);
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_done", 64'(done), 64'd0);
      chk("rst_mid_status", 64'(game_status), 64'd0);
      chk("rst_mid_dir", 64'(win_dir), 64'd0);
      chk("rst_mid_col", 64'(win_col), 64'd0);
      chk("rst_mid_mask", 64'(win_mask), 64'd0);
      saw = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (done) saw = 1'b1;
      end
      chk("rst_mid_no_done", 64'(saw), 64'd0);

      // Reset and start together: reset wins.
      game_board   = 16'h000F;
      player_cells = 16'h0000;
      start        = 1'b1;
      rst          = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      chk("rst_start_busy", 64'(busy), 64'd0);
      saw = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done || busy) saw = 1'b1;
      end
      $display("case rst_start: activity seen %b", saw);
      chk("rst_start_idle", 64'(saw), 64'd0);

      run_a("after_reset", 16'h000F, 16'h0000, 2, 2'b01, 2'd0, 2'd0, 2'd0, 16'h000F, 0);

      // 6x7 board, anti-diagonal from (2,6) owned by player 1: candidate 147.
      @(negedge clk);
      game_board_b   = 42'h041_0410_0000;
      player_cells_b = '0;
      start_b        = 1'b1;
      @(negedge clk);
      start_b      = 1'b0;
      game_board_b = '1;
      cyc = 1;
      while (!done_b && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      if (!done_b) begin
         n_cmp++;
         n_bad++;
         $display("FAIL b6x7_timeout: no done after %0d cycles", cyc);
      end
      $display("case b6x7: done in cycle %0d status %b dir %0d row %0d col %0d mask %h",
               cyc, game_status_b, win_dir_b, win_row_b, win_col_b, win_mask_b);
      model_eval(6, 7, 4, 64'h41_0410_0000, 64'h0, k, st, dr, wr, wc, mk);
      chk("b6x7_done_cycle", 64'(cyc), 64'd148);
      chk("b6x7_done_model", 64'(cyc), 64'(k + 1));
      chk("b6x7_status", 64'(game_status_b), 64'd1);
      chk("b6x7_dir", 64'(win_dir_b), 64'd3);
      chk("b6x7_row", 64'(win_row_b), 64'd2);
      chk("b6x7_col", 64'(win_col_b), 64'd6);
      chk("b6x7_mask", 64'(win_mask_b), 64'h041_0410_0000);
      chk("b6x7_mask_model", 64'(win_mask_b), mk);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
